// File: rtl/sys_pll.sv
`default_nettype none
// ============================================================================
// sys_pll : clkin1 period-lock detector driving five clk_tb-derived dividers.
// Optional macro SYS_PLL_LOL_EN adds loss-of-lock on clkin1 timeout.
// Revision: 1.0
// ============================================================================
module sys_pll #(
  parameter int ODIV0       = 2,
  parameter int ODIV1       = 4,
  parameter int ODIV2       = 10,
  parameter int ODIV3       = 20,
  parameter int ODIV4       = 100,
  parameter int LOCK_CYCLES = 16,
  parameter int PERIOD_TOL  = 1,
  parameter int LOL_TIMEOUT = 1024
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic clkin1,
  output logic clkout0,
  output logic clkout1,
  output logic clkout2,
  output logic clkout3,
  output logic clkout4,
  output logic pll_lock
);

  localparam int                NUM_OUT  = 5;
  localparam int                GOOD_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CYCLES);
  localparam logic [15:0]       TOL      = 16'(PERIOD_TOL);

  // Illegal configurations are rejected at elaboration rather than misbehaving.
  if ((ODIV0 < 2) || ((ODIV0 % 2) != 0) || (ODIV1 < 2) || ((ODIV1 % 2) != 0) ||
      (ODIV2 < 2) || ((ODIV2 % 2) != 0) || (ODIV3 < 2) || ((ODIV3 % 2) != 0) ||
      (ODIV4 < 2) || ((ODIV4 % 2) != 0)) begin : g_bad_odiv
    $error("sys_pll: every ODIVn must be even and >= 2");
  end
  if ((LOCK_CYCLES < 1) || (LOL_TIMEOUT < 2) || (LOL_TIMEOUT > 65535)) begin : g_bad_lock
    $error("sys_pll: LOCK_CYCLES or LOL_TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } meas_state_t;

  logic              sync1_q, sync2_q, sync_prev_q;
  logic              w_edge;
  logic [15:0]       per_cnt_q, per_cnt_d;
  logic [15:0]       prev_per_q, prev_per_d;
  logic [15:0]       w_diff;
  logic              w_match;
  logic              w_timeout;
  meas_state_t       state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic              lock_q, lock_d;
  logic [NUM_OUT-1:0] w_clkout;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= clkin1;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  assign w_edge = sync2_q & ~sync_prev_q;

  always_comb begin
    per_cnt_d = per_cnt_q;
    if (w_edge) begin
      per_cnt_d = 16'd1;
    end else if (per_cnt_q != 16'hFFFF) begin
      per_cnt_d = per_cnt_q + 16'd1;
    end
  end

  assign w_diff  = (per_cnt_q >= prev_per_q) ? (per_cnt_q - prev_per_q)
                                             : (prev_per_q - per_cnt_q);
  assign w_match = (w_diff <= TOL);

`ifdef SYS_PLL_LOL_EN
  localparam logic [15:0] TIMEOUT = 16'(LOL_TIMEOUT);
  assign w_timeout = ~w_edge & (per_cnt_q == TIMEOUT);
`else
  assign w_timeout = 1'b0;
`endif

  // First edge only arms; second captures a reference period; later edges compare.
  always_comb begin
    state_d    = state_q;
    prev_per_d = prev_per_q;
    good_cnt_d = good_cnt_q;
    lock_d     = lock_q | (good_cnt_q == GOOD_MAX);
    if (w_timeout) begin
      state_d    = ST_ARM;
      good_cnt_d = '0;
      lock_d     = 1'b0;
    end else if (w_edge) begin
      case (state_q)
        ST_ARM: begin
          state_d = ST_FIRST;
        end
        ST_FIRST: begin
          prev_per_d = per_cnt_q;
          state_d    = ST_TRACK;
        end
        ST_TRACK: begin
          prev_per_d = per_cnt_q;
          if (!w_match) begin
            good_cnt_d = '0;
          end else if (good_cnt_q != GOOD_MAX) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
        default: begin
          state_d = ST_ARM;
        end
      endcase
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q  <= 16'd0;
      prev_per_q <= 16'd0;
      state_q    <= ST_ARM;
      good_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      prev_per_q <= prev_per_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      lock_q     <= lock_d;
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_div
    localparam int DIV  = (gi == 0) ? ODIV0 : (gi == 1) ? ODIV1 :
                          (gi == 2) ? ODIV2 : (gi == 3) ? ODIV3 : ODIV4;
    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;

    always_comb begin
      cnt_d = cnt_q;
      clk_d = clk_q;
      if (!lock_q) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        clk_q <= clk_d;
      end
    end

    assign w_clkout[gi] = clk_q;
  end

  assign clkout0  = w_clkout[0];
  assign clkout1  = w_clkout[1];
  assign clkout2  = w_clkout[2];
  assign clkout3  = w_clkout[3];
  assign clkout4  = w_clkout[4];
  assign pll_lock = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_pll.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sys_pll : directed self-checking bench for sys_pll (default parameters).
// Revision: 1.0
// ============================================================================
module tb_sys_pll;

  logic clk_tb = 1'b0;
  logic rst_n  = 1'b0;
  logic clkin1;
  logic clkout0, clkout1, clkout2, clkout3, clkout4;
  logic pll_lock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit ref_run       = 1'b0;
  bit use_b         = 1'b0;
  int per_a         = 10;
  int per_b         = 10;
  int per_once      = 0;
  int last_rise_cyc = 0;

  sys_pll dut (
    .clk_tb  (clk_tb),
    .rst_n   (rst_n),
    .clkin1  (clkin1),
    .clkout0 (clkout0),
    .clkout1 (clkout1),
    .clkout2 (clkout2),
    .clkout3 (clkout3),
    .clkout4 (clkout4),
    .pll_lock(pll_lock)
  );

  always #5 clk_tb = ~clk_tb;

  always @(posedge clk_tb) cyc <= cyc + 1;

  // Reference generator: one period of per_once if set, else alternating per_a/per_b.
  initial begin : ref_gen
    int ph;
    int cur;
    ph = 0;
    cur = 10;
    clkin1 = 1'b0;
    forever begin
      @(negedge clk_tb);
      if (!ref_run) begin
        clkin1 = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0) begin
          if (per_once != 0) begin
            cur = per_once;
            per_once = 0;
          end else begin
            cur = use_b ? per_b : per_a;
            use_b = ~use_b;
          end
          last_rise_cyc = cyc;
        end
        clkin1 = (ph < cur / 2);
        ph = (ph + 1 >= cur) ? 0 : ph + 1;
      end
    end
  end

  function automatic logic [4:0] outs();
    return {clkout4, clkout3, clkout2, clkout1, clkout0};
  endfunction

  task automatic wait_lock(input int budget, output int n);
    n = 0;
    while (pll_lock !== 1'b1 && n < budget + 10) begin
      @(negedge clk_tb);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ref_run = 1'b0;
    repeat (10) @(negedge clk_tb);
    checks++;
    if (pll_lock !== 1'b0) begin
      errors++;
      $display("FAIL reset_lock: got %b, required 0", pll_lock);
    end
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL reset_clkout: got %b, required 00000", outs());
    end
  endtask

  task automatic test_lock_acquire();
    int n;
    int first_c0;
    int first_c4;
    bit pre_bad;
    bit fell;
    @(posedge clk_tb);
    #1;
    per_a = 10;
    per_b = 10;
    rst_n = 1'b1;
    ref_run = 1'b1;
    n = 0;
    pre_bad = 1'b0;
    while (pll_lock !== 1'b1 && n < 250) begin
      @(negedge clk_tb);
      n++;
      if (outs() !== 5'b0) pre_bad = 1'b1;
    end
    checks++;
    if (pre_bad !== 1'b0) begin
      errors++;
      $display("FAIL prelock_clkout: got nonzero clkout before lock, required all 0");
    end
    checks++;
    if (pll_lock !== 1'b1 || n > 194) begin
      errors++;
      $display("FAIL lock_time: got %0d cycles (lock=%b), required <= 194", n, pll_lock);
    end
    first_c0 = -1;
    first_c4 = -1;
    fell = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk_tb);
      if (pll_lock !== 1'b1) fell = 1'b1;
      if (first_c0 < 0 && clkout0 === 1'b1) first_c0 = k;
      if (first_c4 < 0 && clkout4 === 1'b1) first_c4 = k;
    end
    checks++;
    if (first_c0 != 1) begin
      errors++;
      $display("FAIL clkout0_first_rise: got %0d, required 1", first_c0);
    end
    checks++;
    if (first_c4 != 50) begin
      errors++;
      $display("FAIL clkout4_first_rise: got %0d, required 50", first_c4);
    end
    checks++;
    if (fell !== 1'b0) begin
      errors++;
      $display("FAIL lock_held: pll_lock dropped after lock, required steady 1");
    end
  endtask

  task automatic test_clkout_periods();
    int exp_rise [5] = '{500, 250, 100, 50, 10};
    int rises [5];
    int highs [5];
    logic [4:0] p;
    logic [4:0] s;
    for (int i = 0; i < 5; i++) begin
      rises[i] = 0;
      highs[i] = 0;
    end
    @(negedge clk_tb);
    p = outs();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_tb);
      s = outs();
      for (int i = 0; i < 5; i++) begin
        if (s[i] === 1'b1 && p[i] === 1'b0) rises[i]++;
        if (s[i] === 1'b1) highs[i]++;
      end
      p = s;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rises[i] != exp_rise[i]) begin
        errors++;
        $display("FAIL clkout%0d_rises: got %0d, required %0d", i, rises[i], exp_rise[i]);
      end
      checks++;
      if (highs[i] != 500) begin
        errors++;
        $display("FAIL clkout%0d_high: got %0d, required 500", i, highs[i]);
      end
    end
  endtask

  task automatic test_single_long_period();
    bit dropped;
    bit c0_glitch;
    int c2_rises;
    logic [4:0] p;
    logic [4:0] s;
    @(posedge clk_tb);
    #1;
    per_once = 13;
    dropped = 1'b0;
    c0_glitch = 1'b0;
    c2_rises = 0;
    @(negedge clk_tb);
    p = outs();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_tb);
      s = outs();
      if (pll_lock !== 1'b1) dropped = 1'b1;
      if (s[0] === p[0]) c0_glitch = 1'b1;
      if (s[2] === 1'b1 && p[2] === 1'b0) c2_rises++;
      p = s;
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL long_period_lock: pll_lock dropped, required steady 1");
    end
    checks++;
    if (c0_glitch !== 1'b0) begin
      errors++;
      $display("FAIL long_period_clkout0: clkout0 missed a toggle, required toggle every cycle");
    end
    checks++;
    if (c2_rises != 40) begin
      errors++;
      $display("FAIL long_period_clkout2: got %0d rises, required 40", c2_rises);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(posedge clk_tb);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pll_lock !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_lock: got %b, required 0", pll_lock);
    end
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_clkout: got %b, required 00000", outs());
    end
    @(posedge clk_tb);
    #1;
    rst_n = 1'b1;
    wait_lock(194, n);
    checks++;
    if (pll_lock !== 1'b1 || n > 194) begin
      errors++;
      $display("FAIL async_relock_time: got %0d cycles (lock=%b), required <= 194", n, pll_lock);
    end
  endtask

  task automatic test_mismatch();
    bit saw_lock;
    bit saw_clk;
    int n;
    @(posedge clk_tb);
    #1;
    rst_n = 1'b0;
    ref_run = 1'b0;
    repeat (5) @(posedge clk_tb);
    #1;
    per_a = 10;
    per_b = 14;
    use_b = 1'b0;
    rst_n = 1'b1;
    ref_run = 1'b1;
    saw_lock = 1'b0;
    saw_clk = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk_tb);
      if (pll_lock !== 1'b0) saw_lock = 1'b1;
      if (outs() !== 5'b0) saw_clk = 1'b1;
    end
    checks++;
    if (saw_lock !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_lock: got lock with 10/14 periods, required 0");
    end
    checks++;
    if (saw_clk !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_clkout: got clkout activity, required all 0");
    end
    @(posedge clk_tb);
    #1;
    per_b = 10;
    wait_lock(250, n);
    checks++;
    if (pll_lock !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_recover: got lock=%b after %0d cycles, required 1", pll_lock, n);
    end
  endtask

  task automatic test_lol();
    int n;
    int delta;
    bit dropped;
    @(posedge clk_tb);
    #1;
    ref_run = 1'b0;
`ifdef SYS_PLL_LOL_EN
    n = 0;
    while (pll_lock !== 1'b0 && n < 1200) begin
      @(negedge clk_tb);
      n++;
    end
    // 1025 cycles after the synchronised edge, which trails the pin by 2 cycles.
    delta = cyc - last_rise_cyc;
    checks++;
    if (pll_lock !== 1'b0 || delta < 1025 || delta > 1029) begin
      errors++;
      $display("FAIL lol_time: got %0d cycles (lock=%b), required 1027 +/-2", delta, pll_lock);
    end
    repeat (5) @(negedge clk_tb);
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL lol_clkout: got %b, required 00000", outs());
    end
    @(posedge clk_tb);
    #1;
    ref_run = 1'b1;
    wait_lock(194, n);
    checks++;
    if (pll_lock !== 1'b1 || n > 194) begin
      errors++;
      $display("FAIL lol_relock_time: got %0d cycles (lock=%b), required <= 194", n, pll_lock);
    end
`else
    dropped = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_tb);
      if (pll_lock !== 1'b1) dropped = 1'b1;
    end
    delta = cyc - last_rise_cyc;
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL nolol_hold: pll_lock dropped %0d cycles after stop, required steady 1", delta);
    end
    @(posedge clk_tb);
    #1;
    ref_run = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_tb);
      if (pll_lock !== 1'b1) dropped = 1'b1;
    end
    n = 0;
    checks++;
    if (dropped !== 1'b0 || clkout0 === clkout0 && n != 0) begin
      errors++;
      $display("FAIL nolol_restart: pll_lock dropped after restart, required steady 1");
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_clkout_periods();
    test_single_long_period();
    test_async_reset();
    test_mismatch();
    test_lol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
